// File: rtl/mix_columns_ctrl.sv
// mix_columns_ctrl -- sequencer for the byte-serial MixColumns datapath.
//
// Accepts a 128-bit AES state on in_valid/in_ready. It streams the 16 bytes
// column by column to the datapath on mc_in_byte/mc_enable. It captures the
// 16 result bytes from mc_out_byte at the datapath's fixed latency. It then
// returns the reassembled state on out_valid/out_ready. last_round=1 bypasses
// the datapath and hands in_state straight to out_state.
//
// Ports
//   clock, reset_n          clock (rising edge), async active-low reset
//   in_valid/in_ready       input handshake; in_state, last_round qualified by it
//   out_valid/out_ready     output handshake; out_state qualified by out_valid
//   mc_in_byte, mc_enable   byte and accumulate mask to datapath (registered)
//   mc_out_byte             result byte from datapath
//   busy                    FSM not in IDLE
//   blk_count, byp_count    (MC_PERF_CNT_EN only) output / bypass handshake counts
//
// Byte order: byte 0 = [127:120], column c = bytes 4c..4c+3.
// Optional build macro: MC_PERF_CNT_EN adds the two handshake counters.
module mix_columns_ctrl #(
  parameter int MC_LAT = 1            // datapath latency, legal 1..4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [7:0]   mc_in_byte,
  output logic [7:0]   mc_enable,
  input  logic [7:0]   mc_out_byte,
  output logic         busy
`ifdef MC_PERF_CNT_EN
  ,
  output logic [15:0]  blk_count,
  output logic [15:0]  byp_count
`endif
);

  // vld_pipe[0] marks a fed byte sitting on mc_in_byte. vld_pipe[STAGES] is
  // high in the cycle whose closing edge must sample that byte's result.
  // That edge is 3+MC_LAT edges after the edge that launched the byte.
  localparam int STAGES = MC_LAT + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, FEED, DRAIN, HOLD} state_t;

  state_t              state, state_nxt;
  logic [127:0]        st_q;
  logic [3:0]          feed_idx;
  logic [3:0]          cap_idx;
  logic [STAGES:0]     vld_pipe;
  logic                accept, cap_fire, cap_last, out_fire;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign cap_fire = vld_pipe[STAGES] & ((state == FEED) | (state == DRAIN));
  assign cap_last = cap_fire & (cap_idx == 4'd15);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_round ? HOLD : FEED;
      FEED:    if (feed_idx == 4'd15) state_nxt = DRAIN;
      DRAIN:   if (cap_last) state_nxt = HOLD;
      HOLD:    if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are written back into st_q in place. Result r is captured
  // at least 4 cycles after byte r was read out, so its slot is free by then.
  // This means one 128-bit buffer serves as both feed source and capture target.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q       <= '0;
      feed_idx   <= '0;
      cap_idx    <= '0;
      vld_pipe   <= '0;
      mc_in_byte <= '0;
      mc_enable  <= '0;
      out_valid  <= 1'b0;
      out_state  <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      vld_pipe[0]        <= (state == FEED);
      mc_in_byte         <= '0;
      mc_enable          <= '0;
      case (state)
        IDLE: if (accept) begin
          if (last_round) begin
            out_state <= in_state;
            out_valid <= 1'b1;
          end else begin
            st_q     <= in_state;
            feed_idx <= '0;
            cap_idx  <= '0;
          end
        end
        FEED: begin
          // ~idx == 15-idx selects byte idx counted from the MSB end
          mc_in_byte <= st_q[{~feed_idx, 3'b000} +: 8];
          mc_enable  <= (feed_idx[1:0] == 2'd0) ? 8'h00 : 8'hFF;
          feed_idx   <= feed_idx + 4'd1;
        end
        HOLD: if (out_fire) out_valid <= 1'b0;
        default: ;
      endcase
      if (cap_fire) begin
        st_q[{~cap_idx, 3'b000} +: 8] <= mc_out_byte;
        if (cap_idx != 4'd15) cap_idx <= cap_idx + 4'd1;
      end
      if (cap_last) begin
        out_state <= {st_q[127:8], mc_out_byte};
        out_valid <= 1'b1;
      end
    end
  end

`ifdef MC_PERF_CNT_EN
  logic byp_q;   // the state now in flight took the bypass path

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byp_q     <= 1'b0;
      blk_count <= '0;
      byp_count <= '0;
    end else begin
      if (accept) byp_q <= last_round;
      if (out_fire) begin
        blk_count <= blk_count + 16'd1;
        if (byp_q) byp_count <= byp_count + 16'd1;
      end
    end
  end
`endif

endmodule
